// File: rtl/store_buffer_if.sv
// Store-side and memory-side write channels of the store buffer.
// The slave modport is the buffer's view; master is the surrounding logic.
interface store_buffer_if #(
  parameter int unsigned AW = 32
);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wmask;

  logic          mem_wvalid;
  logic          mem_wready;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;

  modport master (
    output st_valid, st_addr, st_wdata, st_wmask, mem_wready,
    input  st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wmask
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_wmask, mem_wready,
    output st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer between lane alignment and data memory, with load-conflict detect.
// Optional STORE_BUF_MERGE_EN: same-word stores merge into the youngest non-head entry.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  store_buffer_if.slave            bus,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_conflict,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = PW - 1;
  localparam int unsigned WW = AW - 2;

  typedef struct packed {
    logic [WW-1:0] waddr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
  } entry_t;

  entry_t        ent_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;

  logic [PW-1:0] used_c;
  logic          full_c;
  logic          empty_c;
  logic [IW-1:0] wr_idx_c;
  logic [IW-1:0] rd_idx_c;
  logic [WW-1:0] st_word_c;
  logic [WW-1:0] ld_word_c;
  logic          merge_c;
  logic          push_c;
  logic          pop_c;
  logic          unused_bits_c;

  assign used_c    = PW'(wr_ptr_q - rd_ptr_q);
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign wr_idx_c  = wr_ptr_q[IW-1:0];
  assign rd_idx_c  = rd_ptr_q[IW-1:0];
  assign st_word_c = bus.st_addr[AW-1:2];
  assign ld_word_c = ld_addr[AW-1:2];

  // Byte-offset bits carry no meaning for word-granular tracking.
  assign unused_bits_c = ^{bus.st_addr[1:0], ld_addr[1:0]};

`ifdef STORE_BUF_MERGE_EN
  logic [IW-1:0] yng_idx_c;
  assign yng_idx_c = IW'(wr_idx_c - IW'(1));
  // Never merge into the head: it may be mid-handshake with memory.
  assign merge_c   = (used_c >= PW'(2)) && (ent_q[yng_idx_c].waddr == st_word_c) &&
                     (bus.st_wmask != 4'b0000);
`else
  assign merge_c   = 1'b0;
`endif

  assign bus.st_ready = !full_c || merge_c;
  assign push_c       = bus.st_valid && bus.st_ready && (bus.st_wmask != 4'b0000) && !merge_c;
  assign pop_c        = !empty_c && bus.mem_wready;

  assign bus.mem_wvalid = !empty_c;
  assign bus.mem_waddr  = {ent_q[rd_idx_c].waddr, 2'b00};
  assign bus.mem_wdata  = ent_q[rd_idx_c].wdata;
  assign bus.mem_wmask  = ent_q[rd_idx_c].wmask;
  assign empty          = empty_c;
  assign count          = used_c;

  // Pointer state; reset drops every queued store including the in-flight head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= PW'(wr_ptr_q + PW'(1));
      if (pop_c)  rd_ptr_q <= PW'(rd_ptr_q + PW'(1));
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      ent_q[wr_idx_c] <= '{waddr: st_word_c, wdata: bus.st_wdata, wmask: bus.st_wmask};
    end
`ifdef STORE_BUF_MERGE_EN
    if (bus.st_valid && merge_c) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.st_wmask[b]) ent_q[yng_idx_c].wdata[8*b +: 8] <= bus.st_wdata[8*b +: 8];
      end
      ent_q[yng_idx_c].wmask <= ent_q[yng_idx_c].wmask | bus.st_wmask;
    end
`endif
  end

  // An entry leaving this cycle still blocks the load until it is gone.
  always_comb begin
    logic          hit;
    logic [IW-1:0] off;
    hit = 1'b0;
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = IW'(IW'(i) - rd_idx_c);
      if (({1'b0, off} < used_c) && (ent_q[i].waddr == ld_word_c)) hit = 1'b1;
    end
    if (push_c && (st_word_c == ld_word_c)) hit = 1'b1;
    ld_conflict = ld_valid && hit;
  end

endmodule
